// File: rtl/two_level_predictor_pkg.sv
// Shared lc3b_types package: machine word type, predictor FSM states and
// default predictor geometry used by two_level_predictor and its table.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } lc3b_pred_state;

  localparam int PRED_PC_BITS   = 3;
  localparam int PRED_HIST_BITS = 4;
  localparam int PRED_CTR_BITS  = 2;

endpackage

// File: rtl/two_level_predictor_sat_table.sv
// pred_sat_table: array of saturating counters with a sweep-clear write port,
// one combinational read port and one read-modify-write saturating update port.
module pred_sat_table #(
  parameter int IDX_BITS = 7,
  parameter int WIDTH    = 2
) (
  input  logic                clk,
  input  logic                i_clr_en,
  input  logic [IDX_BITS-1:0] i_clr_idx,
  input  logic [WIDTH-1:0]    i_clr_val,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output logic [WIDTH-1:0]    o_rd_data,
  input  logic                i_upd_en,
  input  logic [IDX_BITS-1:0] i_upd_idx,
  input  logic                i_upd_inc
);

  localparam int              DEPTH   = 1 << IDX_BITS;
  localparam logic [WIDTH-1:0] CTR_MAX = '1;
  localparam logic [WIDTH-1:0] CTR_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] w_updOld;
  logic [WIDTH-1:0] w_updNew;

  assign w_updOld = r_mem[i_upd_idx];

  always_comb begin
    w_updNew = w_updOld;
    if (i_upd_inc) begin
      if (w_updOld != CTR_MAX) begin
        w_updNew = w_updOld + CTR_ONE;
      end
    end else if (w_updOld != '0) begin
      w_updNew = w_updOld - CTR_ONE;
    end
  end

  // Write-first: a read of the entry being updated this cycle sees the new value.
  assign o_rd_data = (i_upd_en && (i_upd_idx == i_rd_idx)) ? w_updNew : r_mem[i_rd_idx];

  always_ff @(posedge clk) begin
    if (i_clr_en) begin
      r_mem[i_clr_idx] <= i_clr_val;
    end else if (i_upd_en) begin
      r_mem[i_upd_idx] <= w_updNew;
    end
  end

endmodule

// File: rtl/two_level_predictor.sv
// Two-level adaptive branch predictor: per-PC local history (BHT) indexing a
// PHT of saturating counters. Optional misprediction counter under PRED_STATS_EN.
module two_level_predictor
  import lc3b_types::*;
#(
  parameter int PC_BITS   = PRED_PC_BITS,
  parameter int HIST_BITS = PRED_HIST_BITS,
  parameter int CTR_BITS  = PRED_CTR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 pred_req,
  input  lc3b_word             pred_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 upd_valid,
  input  lc3b_word             upd_pc,
  input  logic [HIST_BITS-1:0] upd_hist,
  input  logic                 upd_taken,
  input  logic                 upd_mispred,
  output logic [15:0]          mispred_cnt
);

  localparam int                   IDX_BITS  = PC_BITS + HIST_BITS;
  localparam int                   BHT_DEPTH = 1 << PC_BITS;
  localparam int                   PHT_DEPTH = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0]  WEAK_NT   = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [IDX_BITS-1:0]  LAST_IDX  = IDX_BITS'(PHT_DEPTH - 1);
  localparam logic [IDX_BITS-1:0]  IDX_ONE   = IDX_BITS'(1);

  lc3b_pred_state       r_state;
  lc3b_pred_state       w_stateNext;
  logic [IDX_BITS-1:0]  r_sweepIdx;
  logic [IDX_BITS-1:0]  w_sweepIdxNext;
  logic                 w_sweeping;
  logic                 w_running;

  logic [HIST_BITS-1:0] r_bht [BHT_DEPTH];

  logic                 w_clrEn;
  logic                 w_updEn;
  logic                 w_predEn;
  logic [PC_BITS-1:0]   w_predBi;
  logic [PC_BITS-1:0]   w_updBi;
  logic [HIST_BITS-1:0] w_newHist;
  logic [HIST_BITS-1:0] w_predHist;
  logic [IDX_BITS-1:0]  w_predIdx;
  logic [IDX_BITS-1:0]  w_updIdx;
  logic [CTR_BITS-1:0]  w_phtRd;

  logic                 r_predValid;
  logic                 r_predTaken;
  logic [HIST_BITS-1:0] r_predHist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT;
      r_sweepIdx <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_sweepIdx <= w_sweepIdxNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_sweepIdxNext = r_sweepIdx;
    w_sweeping     = 1'b0;
    w_running      = 1'b0;
    if (r_state == INIT) begin
      w_sweeping     = 1'b1;
      w_sweepIdxNext = r_sweepIdx + IDX_ONE;
      if (r_sweepIdx == LAST_IDX) begin
        w_stateNext = RUN;
      end
    end else begin
      w_running = 1'b1;
    end
  end

  // The PHT has no reset of its own, so every write is gated by rst here.
  assign w_clrEn  = w_sweeping && !rst;
  assign w_updEn  = w_running && !rst && upd_valid;
  assign w_predEn = w_running && !rst && pred_req;

  assign w_predBi = pred_pc[PC_BITS:1];
  assign w_updBi  = upd_pc[PC_BITS:1];
  assign w_updIdx = {w_updBi, upd_hist};

  generate
    if (HIST_BITS > 1) begin : g_histShift
      assign w_newHist = {r_bht[w_updBi][HIST_BITS-2:0], upd_taken};
    end else begin : g_histSingle
      assign w_newHist = upd_taken;
    end
  endgenerate

  assign w_predHist = (w_updEn && (w_updBi == w_predBi)) ? w_newHist : r_bht[w_predBi];
  assign w_predIdx  = {w_predBi, w_predHist};

  always_ff @(posedge clk) begin
    if (w_clrEn) begin
      r_bht[r_sweepIdx[PC_BITS-1:0]] <= '0;
    end else if (w_updEn) begin
      r_bht[w_updBi] <= w_newHist;
    end
  end

  pred_sat_table #(
    .IDX_BITS (IDX_BITS),
    .WIDTH    (CTR_BITS)
  ) u_pht (
    .clk       (clk),
    .i_clr_en  (w_clrEn),
    .i_clr_idx (r_sweepIdx),
    .i_clr_val (WEAK_NT),
    .i_rd_idx  (w_predIdx),
    .o_rd_data (w_phtRd),
    .i_upd_en  (w_updEn),
    .i_upd_idx (w_updIdx),
    .i_upd_inc (upd_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_predValid <= 1'b0;
      r_predTaken <= 1'b0;
      r_predHist  <= '0;
    end else begin
      r_predValid <= w_predEn;
      if (w_predEn) begin
        r_predTaken <= w_phtRd[CTR_BITS-1];
        r_predHist  <= w_predHist;
      end
    end
  end

  // Outputs are forced low combinationally so they read zero for the whole reset window.
  assign ready      = !rst && (r_state == RUN);
  assign pred_valid = !rst && r_predValid;
  assign pred_taken = !rst && r_predTaken;
  assign pred_hist  = rst ? '0 : r_predHist;

`ifdef PRED_STATS_EN
  logic [15:0] r_mispredCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mispredCnt <= '0;
    end else if (w_updEn && upd_mispred && (r_mispredCnt != 16'hFFFF)) begin
      r_mispredCnt <= r_mispredCnt + 16'd1;
    end
  end

  assign mispred_cnt = rst ? '0 : r_mispredCnt;
`else
  logic w_unusedMispred;
  assign w_unusedMispred = upd_mispred;
  assign mispred_cnt     = '0;
`endif

  logic w_unusedPcBits;
  assign w_unusedPcBits = ^{pred_pc[15:PC_BITS+1], pred_pc[0], upd_pc[15:PC_BITS+1], upd_pc[0]};

endmodule

// File: tb/tb_two_level_predictor.sv
// Directed self-checking bench for two_level_predictor (default geometry);
// misprediction counter expectations follow PRED_STATS_EN.
module tb_two_level_predictor;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic       pred_req;
  lc3b_word   pred_pc;
  logic       pred_valid;
  logic       pred_taken;
  logic [3:0] pred_hist;
  logic       upd_valid;
  lc3b_word   upd_pc;
  logic [3:0] upd_hist;
  logic       upd_taken;
  logic       upd_mispred;
  logic [15:0] mispred_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  two_level_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .pred_req    (pred_req),
    .pred_pc     (pred_pc),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_hist   (pred_hist),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_hist    (upd_hist),
    .upd_taken   (upd_taken),
    .upd_mispred (upd_mispred),
    .mispred_cnt (mispred_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; on return we sit 1ns after the edge with inputs idle.
  task automatic applyStimulus(input logic req, input lc3b_word pc, input logic upd,
                               input lc3b_word upc, input logic [3:0] uhist,
                               input logic utaken, input logic umis);
    pred_req    = req;
    pred_pc     = pc;
    upd_valid   = upd;
    upd_pc      = upc;
    upd_hist    = uhist;
    upd_taken   = utaken;
    upd_mispred = umis;
    @(posedge clk);
    #1;
    pred_req    = 1'b0;
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
  endtask

  task automatic doUpdate(input lc3b_word pc, input logic [3:0] hist, input logic taken);
    applyStimulus(1'b0, 16'h0000, 1'b1, pc, hist, taken, 1'b0);
  endtask

  task automatic doPredict(input string tag, input lc3b_word pc,
                           input logic expTaken, input logic [3:0] expHist);
    applyStimulus(1'b1, pc, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
    checkOutput({tag, " valid"}, pred_valid, 1);
    checkOutput({tag, " taken"}, pred_taken, expTaken);
    checkOutput({tag, " hist"},  pred_hist,  expHist);
  endtask

  // Counts edges from reset release until ready; optionally floods INIT with traffic.
  task automatic waitReady(input string tag, input int expCycles, input bit flood);
    int  cnt = 0;
    bit  sawValid = 1'b0;
    if (flood) begin
      pred_req    = 1'b1;
      pred_pc     = 16'h0004;
      upd_valid   = 1'b1;
      upd_pc      = 16'h0004;
      upd_hist    = 4'h0;
      upd_taken   = 1'b1;
      upd_mispred = 1'b1;
    end
    while (!ready && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (pred_valid) sawValid = 1'b1;
    end
    pred_req    = 1'b0;
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
    checkOutput({tag, " cycles to ready"}, cnt, expCycles);
    checkOutput({tag, " no pred_valid in INIT"}, sawValid, 0);
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [15:0] expStats;
    rst = 1'b1;
    pred_req = 1'b0; pred_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_hist = '0; upd_taken = 1'b0; upd_mispred = 1'b0;

    $display("[TB] reset and initial sweep");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ready", ready, 0);
    checkOutput("reset pred_valid", pred_valid, 0);
    checkOutput("reset mispred_cnt", mispred_cnt, 0);
    rst = 1'b0;
    waitReady("sweep1", 128, 1'b1);
    checkOutput("post-init mispred_cnt", mispred_cnt, 0);

    doPredict("first pc4", 16'h0004, 1'b0, 4'b0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
    checkOutput("pred_valid pulse ends", pred_valid, 0);

    $display("[TB] training");
    doUpdate(16'h0004, 4'b0000, 1'b1);
    doUpdate(16'h0004, 4'b0001, 1'b1);
    doUpdate(16'h0004, 4'b0011, 1'b1);
    doUpdate(16'h0004, 4'b0111, 1'b1);
    doUpdate(16'h0004, 4'b1111, 1'b1);
    doPredict("trained pc4", 16'h0004, 1'b1, 4'b1111);
    doPredict("alias pc14", 16'h0014, 1'b1, 4'b1111);

    $display("[TB] saturation");
    repeat (3) doUpdate(16'h0004, 4'b1111, 1'b1);
    doUpdate(16'h0004, 4'b1111, 1'b0);
    doPredict("after not-taken", 16'h0004, 1'b0, 4'b1110);
    repeat (4) doUpdate(16'h0004, 4'b0101, 1'b1);
    doPredict("sat high then dec", 16'h0004, 1'b1, 4'b1111);
    repeat (3) doUpdate(16'h0008, 4'b0000, 1'b0);
    doPredict("sat low", 16'h0008, 1'b0, 4'b0000);

    $display("[TB] same-cycle bypass");
    applyStimulus(1'b1, 16'h0006, 1'b1, 16'h0006, 4'b0000, 1'b1, 1'b0);
    checkOutput("bypass hist valid", pred_valid, 1);
    checkOutput("bypass hist", pred_hist, 4'b0001);
    checkOutput("bypass hist taken", pred_taken, 0);
    applyStimulus(1'b1, 16'h0006, 1'b1, 16'h0006, 4'b0011, 1'b1, 1'b0);
    checkOutput("bypass ctr hist", pred_hist, 4'b0011);
    checkOutput("bypass ctr taken", pred_taken, 1);
    doPredict("bypass ctr stored", 16'h0006, 1'b1, 4'b0011);

    $display("[TB] back-to-back requests");
    doPredict("b2b first", 16'h0004, 1'b1, 4'b1111);
    doPredict("b2b second", 16'h0008, 1'b0, 4'b0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
    checkOutput("b2b idle", pred_valid, 0);

    $display("[TB] misprediction statistics");
    repeat (5) applyStimulus(1'b0, 16'h0000, 1'b1, 16'h000A, 4'h0, 1'b1, 1'b1);
`ifdef PRED_STATS_EN
    expStats = 16'd5;
`else
    expStats = 16'd0;
`endif
    checkOutput("mispred_cnt 5", mispred_cnt, expStats);
`ifdef PRED_STATS_EN
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, 16'h000A, 4'h0, 1'b1, 1'b1);
    end
    checkOutput("mispred_cnt saturate", mispred_cnt, 16'hFFFF);
`endif

    $display("[TB] reset mid-operation");
    doUpdate(16'h0004, 4'b1111, 1'b1);
    applyStimulus(1'b1, 16'h0004, 1'b1, 16'h0004, 4'b1111, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("mid-run rst pred_valid", pred_valid, 0);
    checkOutput("mid-run rst ready", ready, 0);
    checkOutput("mid-run rst mispred_cnt", mispred_cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("mid-sweep ready", ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid-sweep rst ready", ready, 0);
    rst = 1'b0;
    waitReady("sweep2", 128, 1'b0);
    doPredict("after re-init", 16'h0004, 1'b0, 4'b0000);
    checkOutput("after re-init mispred_cnt", mispred_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
